pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It tracks destination-register metadata for every stage from EX to WB, and detects load-use hazards at ID. From that it generates stall and flush controls plus per-operand forwarding selects for the EX stage. Pipeline depth, the branch-resolve stage and register-address width are parameters, so deeper memory pipelines reuse the same block.

## Interface
- N_STAGES, 5, total stages: 0 IF, 1 ID, 2 EX, 3..N_STAGES-2 MEM, N_STAGES-1 WB; legal ≥5
- BR_STAGE, 3, stage whose branch outcome is final; legal 2..N_STAGES-2
- ADDR_W, 5, register address width
- SEL_W, $clog2(N_STAGES), forwarding-select width (derived)
- clk  in  1  clock, rising edge
- arst_n  in  1  reset, asynchronous assertion, active-low
- enable  in  1  global advance; low freezes all state
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  ADDR_W  ID source registers
- id_uses_rs1, id_uses_rs2  in  1  source actually read
- id_rd  in  ADDR_W  ID destination
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- br_taken  in  1  taken branch/jump currently in BR_STAGE
- stall  out  1  hold PC and IF/ID; bubble into ID/EX
- flush  out  1  kill IF/ID and all stages younger than BR_STAGE
- fwd_a, fwd_b  out  SEL_W  EX operand source: 0 = register file, k = result of instruction in stage k
- ex_valid  out  1  EX entry is valid
- stall_cnt, flush_cnt  out  32  event counters

## Operation
- State: one entry per stage k in 2..N_STAGES-1: {valid, rd, reg_write, mem_read}. Stage 2 additionally holds {rs1, rs2, uses_rs1, uses_rs2}.
- Load-use hazard: id_valid, id_uses_rsX and id_rsX≠0, with some stage k in 2..N_STAGES-3 holding valid & mem_read & rd==id_rsX. This covers both operands.
- stall = hazard & !br_taken.
- flush = br_taken. Flush has priority: stall is forced low and no stall is counted in that cycle.
- Advance on each rising edge with enable=1:
  - Stage 2 loads the ID fields when there is no stall and no flush, with valid=id_valid.
  - On stall or flush, stage 2 becomes a bubble (all fields 0).
  - Stage k>2 takes stage k-1.
  - On flush, stages 2..BR_STAGE become invalid after the shift. The branch itself moves on to BR_STAGE+1.
- Forwarding, per operand X of the EX entry:
  - Condition: ex valid, uses_rsX, rsX≠0.
  - Select the smallest k in 3..N_STAGES-1 with valid & reg_write & rd==rsX (youngest producer wins); otherwise 0.
  - The stall rule guarantees a matching load sits at stage N_STAGES-1 or beyond. No extra check is required.
- The register file is not write-through. WB-stage forwarding (k=N_STAGES-1) covers same-cycle writes.
- Counters:
  - stall_cnt increments on each edge with enable & stall.
  - flush_cnt increments on each edge with enable & flush.
  - Both wrap modulo 2^32.
- enable=0: no state or counter changes. Combinational outputs still reflect current state and inputs.

## Timing
- Reset (asynchronous, arst_n=0): all entries invalid, all fields 0, counters 0.
  - Outputs then evaluate to: stall=0 (given id_valid=0), flush=br_taken, fwd_a=fwd_b=0, ex_valid=0.
- stall, flush, fwd_a and fwd_b are combinational from registered state and same-cycle inputs. There are no registered outputs besides ex_valid and the counters.
- Load-use penalty is N_STAGES-4 stall cycles (1 at N_STAGES=5). There is no penalty for ALU-to-ALU dependencies.
- Taken-branch penalty: the BR_STAGE instructions in stages 0..BR_STAGE-1 are killed.
- Reset mid-stall or mid-flush: everything clears immediately. The first cycle after release has no pending hazards.

## Test plan
- N=5, BR=3, load-use: `ld x5` then `add x6,x5,x1` → stall=1 for exactly 1 cycle, then add in EX with fwd_a=4, fwd_b=0, stall_cnt=1.
- ALU chain: `add x5`, `sub x5`, `add x7,x5,x5` → no stall; in EX fwd_a=fwd_b=3 (younger sub wins over add at stage 4).
- x0 destination: `add x0,…` then `add x7,x0,x0` → fwd_a=fwd_b=0, no stall even if the producer is a load to x0.
- Flush vs stall: load-use pending in ID while br_taken=1 → flush=1, stall=0, stall_cnt unchanged, flush_cnt+1; next cycle stages 2..3 are invalid (ex_valid=0) and the branch is at stage 4.
- Freeze and reset: enable=0 for 3 cycles during a stall → stall held at 1, counters unchanged. Then arst_n pulse → all outputs at reset values, counters 0.
- N=7, BR=4: load x5 then a dependent consumer → 3 stall cycles; consumer in EX with fwd_a=6; a taken branch kills the instructions in stages 0..3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush and EX operand forwarding control
// for an in-order pipeline with parametrised depth.
module pipeline_hazard_ctrl #(
    parameter int N_STAGES = 5,
    parameter int BR_STAGE = 3,
    parameter int ADDR_W   = 5,
    parameter int SEL_W    = $clog2(N_STAGES)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable_i,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rs1_i,
    input  logic [ADDR_W-1:0] id_rs2_i,
    input  logic              id_uses_rs1_i,
    input  logic              id_uses_rs2_i,
    input  logic [ADDR_W-1:0] id_rd_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              br_taken_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic [SEL_W-1:0]  fwd_a_o,
    output logic [SEL_W-1:0]  fwd_b_o,
    output logic              ex_valid_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
);
    localparam int L = N_STAGES - 1;
    localparam int LD_TOP = N_STAGES - 3;

    logic [L:2]             vld_q, vld_d, wr_q, wr_d;
    logic [L:2][ADDR_W-1:0] rd_q, rd_d;
    // mem_read only matters where a load can still cause a load-use stall
    logic [LD_TOP:2]        ld_q, ld_d, hit;
    logic [ADDR_W-1:0]      rs1_q, rs1_d, rs2_q, rs2_d;
    logic                   use1_q, use1_d, use2_q, use2_d;
    logic [31:0]            stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [L:3]             ma, mb;
    logic [L+1:3][SEL_W-1:0] ca, cb;
    logic                   bubble, ex_a, ex_b;

    for (genvar k = 2; k <= LD_TOP; k++) begin : g_hit
        assign hit[k] = vld_q[k] && ld_q[k] &&
                        ((id_uses_rs1_i && id_rs1_i != '0 && rd_q[k] == id_rs1_i) ||
                         (id_uses_rs2_i && id_rs2_i != '0 && rd_q[k] == id_rs2_i));
    end

    assign flush_o = br_taken_i;
    assign stall_o = id_valid_i && (|hit) && !br_taken_i;
    assign bubble  = stall_o || flush_o;

    assign ex_a = vld_q[2] && use1_q && rs1_q != '0;
    assign ex_b = vld_q[2] && use2_q && rs2_q != '0;
    assign ca[L+1] = '0;
    assign cb[L+1] = '0;
    // priority chain: the youngest (lowest-numbered) producer overrides older ones
    for (genvar k = 3; k <= L; k++) begin : g_fwd
        assign ma[k] = ex_a && vld_q[k] && wr_q[k] && rd_q[k] == rs1_q;
        assign mb[k] = ex_b && vld_q[k] && wr_q[k] && rd_q[k] == rs2_q;
        assign ca[k] = ma[k] ? SEL_W'(k) : ca[k+1];
        assign cb[k] = mb[k] ? SEL_W'(k) : cb[k+1];
    end
    assign fwd_a_o = ca[3];
    assign fwd_b_o = cb[3];

    assign vld_d[2] = !bubble && id_valid_i;
    assign wr_d[2]  = !bubble && id_reg_write_i;
    assign ld_d[2]  = !bubble && id_mem_read_i;
    assign rd_d[2]  = bubble ? '0 : id_rd_i;
    assign rs1_d    = bubble ? '0 : id_rs1_i;
    assign rs2_d    = bubble ? '0 : id_rs2_i;
    assign use1_d   = !bubble && id_uses_rs1_i;
    assign use2_d   = !bubble && id_uses_rs2_i;

    for (genvar k = 3; k <= L; k++) begin : g_shift
        assign vld_d[k] = vld_q[k-1] && !(flush_o && k <= BR_STAGE);
        assign wr_d[k]  = wr_q[k-1];
        assign rd_d[k]  = rd_q[k-1];
    end
    for (genvar k = 3; k <= LD_TOP; k++) begin : g_ld
        assign ld_d[k] = ld_q[k-1];
    end

    assign stall_cnt_d = stall_cnt_q + 32'(stall_o);
    assign flush_cnt_d = flush_cnt_q + 32'(flush_o);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            ld_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            use1_q      <= 1'b0;
            use2_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (enable_i) begin
            vld_q       <= vld_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            ld_q        <= ld_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            use1_q      <= use1_d;
            use2_q      <= use2_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid_o  = vld_q[2];
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench driving a 5-stage/BR=3 and a 7-stage/BR=4
// instance with shared stimulus, each checked against an instruction-level pipeline model.
module tb_pipeline_hazard_ctrl;
    typedef struct packed {
        logic       v;
        logic [4:0] r1, r2;
        logic       a1, a2;
        logic [4:0] rd;
        logic       w, l;
    } ins_t;
    typedef struct packed {
        logic        st, fl;
        logic [2:0]  fa, fb;
        logic        ev;
        logic [31:0] sc, fc;
    } exp_t;

    logic clk = 1'b0, arst_n = 1'b0, en = 1'b0, br = 1'b0;
    ins_t id = '0;
    logic st5, fl5, ev5, st7, fl7, ev7;
    logic [2:0] fa5, fb5, fa7, fb7;
    logic [31:0] sc5, fc5, sc7, fc7;

    ins_t pm[2][8];
    logic [31:0] msc[2], mfc[2];
    exp_t q0[$], q1[$];
    exp_t last[2];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.N_STAGES(5), .BR_STAGE(3), .ADDR_W(5)) dut5 (
        .clk(clk), .arst_n(arst_n), .enable_i(en), .id_valid_i(id.v),
        .id_rs1_i(id.r1), .id_rs2_i(id.r2), .id_uses_rs1_i(id.a1), .id_uses_rs2_i(id.a2),
        .id_rd_i(id.rd), .id_reg_write_i(id.w), .id_mem_read_i(id.l), .br_taken_i(br),
        .stall_o(st5), .flush_o(fl5), .fwd_a_o(fa5), .fwd_b_o(fb5), .ex_valid_o(ev5),
        .stall_cnt_o(sc5), .flush_cnt_o(fc5));

    pipeline_hazard_ctrl #(.N_STAGES(7), .BR_STAGE(4), .ADDR_W(5)) dut7 (
        .clk(clk), .arst_n(arst_n), .enable_i(en), .id_valid_i(id.v),
        .id_rs1_i(id.r1), .id_rs2_i(id.r2), .id_uses_rs1_i(id.a1), .id_uses_rs2_i(id.a2),
        .id_rd_i(id.rd), .id_reg_write_i(id.w), .id_mem_read_i(id.l), .br_taken_i(br),
        .stall_o(st7), .flush_o(fl7), .fwd_a_o(fa7), .fwd_b_o(fb7), .ex_valid_o(ev7),
        .stall_cnt_o(sc7), .flush_cnt_o(fc7));

    function automatic int ns(int i);
        return i == 0 ? 5 : 7;
    endfunction
    function automatic int brs(int i);
        return i == 0 ? 3 : 4;
    endfunction

    // model: pm[i][k] is the instruction in stage k (2..ns-1), v=0 means bubble/killed
    function automatic logic m_stall(int i);
        for (int k = 2; k <= ns(i) - 3; k++) begin
            ins_t e = pm[i][k];
            if (e.v && e.l && ((id.a1 && id.r1 != 0 && e.rd == id.r1) ||
                               (id.a2 && id.r2 != 0 && e.rd == id.r2)))
                return id.v && !br;
        end
        return 1'b0;
    endfunction

    function automatic logic [2:0] m_fwd(int i, logic [4:0] rs, logic u);
        if (!pm[i][2].v || !u || rs == 0) return 3'd0;
        for (int k = 3; k < ns(i); k++)
            if (pm[i][k].v && pm[i][k].w && pm[i][k].rd == rs) return 3'(k);
        return 3'd0;
    endfunction

    function automatic exp_t m_exp(int i);
        exp_t e;
        e.st = m_stall(i);
        e.fl = br;
        e.fa = m_fwd(i, pm[i][2].r1, pm[i][2].a1);
        e.fb = m_fwd(i, pm[i][2].r2, pm[i][2].a2);
        e.ev = pm[i][2].v;
        e.sc = msc[i];
        e.fc = mfc[i];
        return e;
    endfunction

    task automatic m_adv(int i);
        logic s;
        s = m_stall(i);
        for (int k = ns(i) - 1; k >= 3; k--) pm[i][k] = pm[i][k-1];
        pm[i][2] = (s || br) ? '0 : id;
        if (br) for (int k = 3; k <= brs(i); k++) pm[i][k].v = 1'b0;
        msc[i] = msc[i] + 32'(s);
        mfc[i] = mfc[i] + 32'(br);
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) pm[i][k] = '0;
            msc[i] = 0;
            mfc[i] = 0;
        end
    endtask

    task automatic tick(input ins_t x, input logic b, input logic e, input logic r);
        @(posedge clk);
        if (arst_n && en) begin
            m_adv(0);
            m_adv(1);
        end
        #1;
        arst_n = !r;
        if (r) m_reset();
        id = x;
        br = b;
        en = e;
        last[0] = m_exp(0);
        last[1] = m_exp(1);
        q0.push_back(last[0]);
        q1.push_back(last[1]);
    endtask

    // hold the instruction in ID while either pipeline is stalling
    task automatic issue(input ins_t x, input logic b);
        tick(x, b, 1'b1, 1'b0);
        for (int n = 0; n < 8 && (last[0].st || last[1].st); n++) tick(x, b, 1'b1, 1'b0);
    endtask

    function automatic ins_t mk(logic [4:0] rd, logic [4:0] r1, logic [4:0] r2,
                                logic a1, logic a2, logic w, logic l);
        return '{1'b1, r1, r2, a1, a2, rd, w, l};
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s n%0d t=%0t got=%0h want=%0h", name, ns(i), $time, act, want);
        end
    endtask

    task automatic cmp(input int i, input exp_t a, input exp_t e);
        chk("stall", i, 32'(a.st), 32'(e.st));
        chk("flush", i, 32'(a.fl), 32'(e.fl));
        chk("fwd_a", i, 32'(a.fa), 32'(e.fa));
        chk("fwd_b", i, 32'(a.fb), 32'(e.fb));
        chk("ex_valid", i, 32'(a.ev), 32'(e.ev));
        chk("stall_cnt", i, a.sc, e.sc);
        chk("flush_cnt", i, a.fc, e.fc);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp(0, '{st5, fl5, fa5, fb5, ev5, sc5, fc5}, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp(1, '{st7, fl7, fa7, fb7, ev7, sc7, fc7}, e);
            end
        end
    end

    initial begin
        ins_t nop, ld5, use5, x;
        nop  = '0;
        ld5  = mk(5, 2, 0, 1, 0, 1, 1);
        use5 = mk(6, 5, 1, 1, 1, 1, 0);
        m_reset();
        tick(nop, 0, 1, 1);
        tick(nop, 0, 1, 1);
        tick(nop, 0, 1, 0);
        // load-use
        issue(ld5, 0);
        issue(use5, 0);
        repeat (6) issue(nop, 0);
        // ALU chain, younger producer wins
        issue(mk(5, 1, 2, 1, 1, 1, 0), 0);
        issue(mk(5, 3, 4, 1, 1, 1, 0), 0);
        issue(mk(7, 5, 5, 1, 1, 1, 0), 0);
        repeat (6) issue(nop, 0);
        // x0 destination, even from a load
        issue(mk(0, 1, 2, 1, 1, 1, 1), 0);
        issue(mk(7, 0, 0, 1, 1, 1, 0), 0);
        repeat (6) issue(nop, 0);
        // flush beats a pending load-use stall
        issue(ld5, 0);
        issue(use5, 1);
        repeat (6) issue(nop, 0);
        // freeze during a stall, then reset mid-stall
        issue(ld5, 0);
        tick(use5, 0, 1, 0);
        repeat (3) tick(use5, 0, 0, 0);
        tick(use5, 0, 1, 0);
        tick(use5, 0, 1, 1);
        tick(nop, 0, 1, 0);
        // randomized traffic with a small register set to provoke dependencies
        for (int c = 0; c < 2000; c++) begin
            if (!(last[0].st || last[1].st)) begin
                x.v  = ($urandom % 8) != 0;
                x.r1 = 5'($urandom_range(0, 6));
                x.r2 = 5'($urandom_range(0, 6));
                x.a1 = ($urandom % 4) != 0;
                x.a2 = ($urandom % 2) != 0;
                x.rd = 5'($urandom_range(0, 6));
                x.w  = ($urandom % 4) != 0;
                x.l  = ($urandom % 3) == 0;
            end
            tick(x, ($urandom % 12) == 0, ($urandom % 10) != 0, ($urandom % 400) == 0);
        end
        tick(nop, 0, 1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
